// File: rtl/monolith_perm_ctrl.sv
// Round-sequencing controller for a Monolith-style permutation: holds the state,
// issues NUM_ROUNDS+1 rounds to an external datapath and hands back the result.
module monolith_perm_ctrl #(
   parameter int WORD_WIDTH = 31,
   parameter int STATE_SIZE = 16,
   parameter int NUM_ROUNDS = 6
) (
   input  logic                                        clk,
   input  logic                                        reset,
   input  logic                                        in_valid,
   output logic                                        in_ready,
   input  logic [STATE_SIZE-1:0][WORD_WIDTH-1:0]       in_state,
   output logic                                        out_valid,
   input  logic                                        out_ready,
   output logic [STATE_SIZE-1:0][WORD_WIDTH-1:0]       out_state,
   output logic                                        rnd_start,
   output logic [$clog2(NUM_ROUNDS+1)-1:0]             rnd_idx,
   output logic                                        rnd_init,
   output logic                                        rnd_last,
   output logic [STATE_SIZE-1:0][WORD_WIDTH-1:0]       rnd_state_out,
   input  logic [STATE_SIZE-1:0][WORD_WIDTH-1:0]       rnd_state_in,
   input  logic                                        rnd_done,
   output logic                                        busy
);

   localparam int IDX_W = $clog2(NUM_ROUNDS + 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ROUNDS);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      DONE
   } state_t;

   state_t                                  state_q, state_d;
   logic [IDX_W-1:0]                        idx_q, idx_d;
   logic [STATE_SIZE-1:0][WORD_WIDTH-1:0]   st_q, st_d;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         idx_q   <= '0;
         st_q    <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         st_q    <= st_d;
      end
   end

   // rnd_done is honoured only while a round is outstanding (ISSUE/WAIT)
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      st_d    = st_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               st_d    = in_state;
               idx_d   = '0;
               state_d = ISSUE;
            end
         end
         ISSUE, WAIT: begin
            if (rnd_done) begin
               st_d = rnd_state_in;
               if (idx_q < LAST_IDX) begin
                  idx_d   = idx_q + IDX_W'(1);
                  state_d = ISSUE;
               end else begin
                  state_d = DONE;
               end
            end else begin
               state_d = WAIT;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      in_ready      = (state_q == IDLE);
      out_valid     = (state_q == DONE);
      busy          = (state_q != IDLE);
      rnd_start     = (state_q == ISSUE);
      rnd_idx       = idx_q;
      rnd_init      = (idx_q == '0);
      rnd_last      = (idx_q == LAST_IDX);
      rnd_state_out = st_q;
      out_state     = st_q;
   end

endmodule

// File: tb/tb_monolith_perm_ctrl.sv
// Randomised bench for monolith_perm_ctrl: emulates the round datapath with
// configurable latency and checks every cycle against a transaction-level model.
module tb_monolith_perm_ctrl;

   localparam int W  = 31;
   localparam int S  = 16;
   localparam int NR = 6;
   localparam int IW = $clog2(NR + 1);

   typedef logic [S-1:0][W-1:0] sv_t;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   sv_t           in_state = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   sv_t           out_state;
   logic          rnd_start;
   logic [IW-1:0] rnd_idx;
   logic          rnd_init;
   logic          rnd_last;
   sv_t           rnd_state_out;
   sv_t           rnd_state_in;
   logic          rnd_done;
   logic          busy;

   always #5 clk = ~clk;

   monolith_perm_ctrl #(
      .WORD_WIDTH (W),
      .STATE_SIZE (S),
      .NUM_ROUNDS (NR)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_state      (in_state),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_state     (out_state),
      .rnd_start     (rnd_start),
      .rnd_idx       (rnd_idx),
      .rnd_init      (rnd_init),
      .rnd_last      (rnd_last),
      .rnd_state_out (rnd_state_out),
      .rnd_state_in  (rnd_state_in),
      .rnd_done      (rnd_done),
      .busy          (busy)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Round function of the emulated datapath; fs selects +1 or an order-sensitive mix
   function automatic sv_t dp(input sv_t v, input int unsigned r, input int unsigned fs);
      sv_t o;
      for (int j = 0; j < S; j++) begin
         longint unsigned x = 64'(v[j]);
         if (fs == 0) x = x + 1;
         else         x = x * 3 + 64'(r);
         o[j] = x[W-1:0];
      end
      return o;
   endfunction

   function automatic sv_t run_all(input sv_t v, input int unsigned fs);
      sv_t t = v;
      for (int r = 0; r <= NR; r++) t = dp(t, r, fs);
      return t;
   endfunction

   // Datapath emulation: dly==0 is combinational, otherwise done follows start by dly cycles
   int   dly = 0;
   int   fsel = 0;
   int   cnt = 0;
   logic dly_done = 1'b0;
   logic inject_done = 1'b0;

   assign rnd_state_in = dp(rnd_state_out, 32'(rnd_idx), fsel);
   assign rnd_done     = ((dly == 0) && rnd_start) || dly_done || inject_done;

   always @(negedge clk) begin
      dly_done = 1'b0;
      if (rnd_start && dly > 0) cnt = dly;
      else if (cnt > 0) begin
         cnt--;
         if (cnt == 0) dly_done = 1'b1;
      end
   end

   // Behavioural model: request bookkeeping plus expected-result queue
   int   cyc = 0;
   bit   m_busy = 0, m_out = 0, m_issue = 0;
   int   m_round = 0;
   sv_t  m_words = '0;
   sv_t  exp_q[$];
   int   acc_count = 0, acc_edge = 0, hs_edge = 0;
   int   starts_seen = 0;
   bit   lat_done = 0;

   always @(posedge clk) begin
      bit done_eff;
      cyc++;
      done_eff = ((dly == 0) && m_issue) || dly_done || inject_done;
      if (!reset) begin
         m_busy = 0; m_out = 0; m_issue = 0; m_round = 0; m_words = '0;
         exp_q.delete();
         starts_seen = 0;
      end else if (!m_busy) begin
         if (in_valid) begin
            m_busy = 1; m_issue = 1; m_round = 0; m_words = in_state;
            exp_q.push_back(run_all(in_state, fsel));
            acc_count++; acc_edge = cyc; starts_seen = 0; lat_done = 0;
         end
      end else if (m_out) begin
         if (out_ready) begin
            m_busy = 0; m_out = 0; hs_edge = cyc;
         end
      end else if (done_eff) begin
         m_words = dp(m_words, m_round, fsel);
         if (m_round == NR) begin m_out = 1; m_issue = 0; end
         else begin m_round++; m_issue = 1; end
      end else begin
         m_issue = 0;
      end
   end

   bit checking = 0;
   int dut_hs = 0;

   always @(negedge clk) begin
      if (checking) begin
         check("in_ready",  in_ready,  !m_busy);
         check("out_valid", out_valid, m_out);
         check("busy",      busy,      m_busy);
         check("rnd_start", rnd_start, m_busy && m_issue);
         check("rnd_idx",   rnd_idx,   m_round);
         check("rnd_init",  rnd_init,  m_round == 0);
         check("rnd_last",  rnd_last,  m_round == NR);
         check("rnd_state_out", rnd_state_out, m_words);
         if (m_out) check("out_state_hold", out_state, m_words);
         if (rnd_start) begin
            check("idx_order", rnd_idx, starts_seen);
            starts_seen++;
         end
         if (m_out && dly == 0 && !lat_done) begin
            check("latency", cyc + 1 - acc_edge, NR + 2);
            lat_done = 1;
         end
         if (out_valid && out_ready) dut_hs++;
         if (m_out && out_ready) begin
            check("start_count", starts_seen, NR + 1);
            if (exp_q.size() == 0) check("result_queue", 0, 1);
            else check("result", out_state, exp_q.pop_front());
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_accept(input sv_t d);
      int a0 = acc_count;
      in_state = d;
      in_valid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         step();
         if (acc_count != a0) break;
      end
      if (acc_count == a0) check("accept_timeout", 0, 1);
      in_valid = 1'b0;
   endtask

   task automatic wait_out();
      for (int i = 0; i < 300; i++) begin
         if (m_out) break;
         step();
      end
      if (!m_out) check("done_timeout", 0, 1);
   endtask

   task automatic handshake();
      int h0 = dut_hs;
      out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step();
         if (dut_hs != h0) break;
      end
      if (dut_hs == h0) check("handshake_timeout", 0, 1);
      out_ready = 1'b0;
   endtask

   function automatic sv_t rand_state();
      sv_t v;
      for (int j = 0; j < S; j++) v[j] = W'($urandom % 32'h7FFF_FFFF);
      return v;
   endfunction

   function automatic sv_t fill(input logic [W-1:0] w);
      sv_t v;
      for (int j = 0; j < S; j++) v[j] = w;
      return v;
   endfunction

   initial begin
      sv_t snap, d1, d2;
      int  h0, a_hs;
      bit  hit;

      // Reset
      reset = 1'b0;
      step();
      checking = 1;
      step();
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_rnd_start", rnd_start, 1'b0);
      check("rst_rnd_idx", rnd_idx, 0);
      check("rst_state", rnd_state_out, sv_t'('0));
      reset = 1'b1;
      step();

      // Combinational datapath, +1 per round from zero
      dly = 0; fsel = 0;
      do_accept('0);
      wait_out();
      handshake();
      check("lit_comb_all7", out_state, fill(W'(7)));

      // Datapath answers three cycles after each start
      dly = 3; fsel = 0;
      do_accept('0);
      wait_out();
      handshake();
      check("lit_wait_all7", out_state, fill(W'(7)));

      // Order-sensitive round function: 0,0,1,5,18,58,179,543
      dly = 0; fsel = 1;
      do_accept('0);
      wait_out();
      handshake();
      check("lit_mix_543", out_state, fill(W'(543)));

      // Stall in DONE while toggling in_valid and rnd_done
      dly = 2; fsel = 1;
      do_accept(rand_state());
      wait_out();
      snap = out_state;
      h0 = dut_hs;
      for (int i = 0; i < 5; i++) begin
         in_valid    = ~in_valid;
         inject_done = ~inject_done;
         step();
         check("stall_stable", out_state, snap);
         check("stall_in_ready", in_ready, 1'b0);
      end
      in_valid = 1'b0;
      inject_done = 1'b0;
      handshake();
      repeat (3) step();
      check("stall_one_hs", dut_hs - h0, 1);

      // Reset during the WAIT of round 3, then a stale rnd_done
      dly = 3; fsel = 0;
      do_accept(rand_state());
      hit = 0;
      for (int i = 0; i < 100; i++) begin
         if (m_busy && !m_out && !m_issue && m_round == 3) begin hit = 1; break; end
         step();
      end
      check("reach_wait3", hit, 1'b1);
      reset = 1'b0;
      step();
      reset = 1'b1;
      check("abort_in_ready", in_ready, 1'b1);
      check("abort_idx", rnd_idx, 0);
      check("abort_out_valid", out_valid, 1'b0);
      repeat (5) step();
      check("stale_ignored", rnd_state_out, sv_t'('0));
      fsel = 1;
      do_accept(rand_state());
      wait_out();
      handshake();

      // Back-to-back requests with in_valid held high
      dly = 1; fsel = 1;
      d1 = rand_state();
      d2 = rand_state();
      do_accept(d1);
      in_state = d2;
      in_valid = 1'b1;
      out_ready = 1'b1;
      a_hs = acc_count;
      for (int i = 0; i < 100; i++) begin
         step();
         if (acc_count != a_hs) break;
      end
      in_valid = 1'b0;
      check("b2b_second_accept", acc_count - a_hs, 1);
      check("b2b_gap", acc_edge - hs_edge, 1);
      out_ready = 1'b0;
      wait_out();
      handshake();

      // Randomised traffic with random latency and back-pressure
      for (int t = 0; t < 20; t++) begin
         dly  = $urandom_range(0, 4);
         fsel = $urandom_range(0, 1);
         do_accept(rand_state());
         h0 = dut_hs;
         for (int i = 0; i < 300; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            in_valid  = 1'($urandom_range(0, 1)) && m_busy;
            step();
            if (dut_hs != h0) break;
         end
         out_ready = 1'b0;
         in_valid  = 1'b0;
         check("rand_hs", dut_hs - h0, 1);
         repeat ($urandom_range(0, 2)) step();
      end

      repeat (3) step();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired after %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/monolith_perm_ctrl.md
MONOLITH_PERM_CTRL -- requirements
Module: monolith_perm_ctrl

Interface
REQ-001 The block SHALL have parameter WORD_WIDTH, default 31, giving the field element width in bits.
REQ-002 The block SHALL have parameter STATE_SIZE, default 16, giving the number of state words.
REQ-003 The block SHALL have parameter NUM_ROUNDS, default 6, giving the number of full rounds after the initial concrete layer.
REQ-004 Ports SHALL be as follows:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- in_valid  in  1  input permutation request.
- in_ready  out  1  controller can accept a request.
- in_state  in  WORD_WIDTH x STATE_SIZE  input state, reduced mod 2^31-1.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_state  out  WORD_WIDTH x STATE_SIZE  permuted state.
- rnd_start  out  1  one-cycle pulse issuing a round to the datapath.
- rnd_idx  out  clog2(NUM_ROUNDS+1)  round index, 0 = initial concrete.
- rnd_init  out  1  high when rnd_idx==0 (concrete only, no bars/bricks).
- rnd_last  out  1  high when rnd_idx==NUM_ROUNDS (no round constants).
- rnd_state_out  out  WORD_WIDTH x STATE_SIZE  state presented to the round datapath.
- rnd_state_in  in  WORD_WIDTH x STATE_SIZE  datapath result.
- rnd_done  in  1  datapath result valid; may assert in the rnd_start cycle (combinational datapath).
- busy  out  1  high in any state other than IDLE.

Function
REQ-005 The FSM SHALL have states IDLE, ISSUE, WAIT and DONE.
REQ-006 In IDLE, in_ready SHALL be 1; on in_valid&&in_ready the block SHALL load in_state into the state register, clear rnd_idx to 0 and go to ISSUE.
REQ-007 In ISSUE, rnd_start SHALL be 1 for exactly that cycle.
REQ-008 In ISSUE or WAIT with rnd_done=1, the block SHALL capture rnd_state_in into the state register.
REQ-009 On that capture, if rnd_idx<NUM_ROUNDS the block SHALL increment rnd_idx and go to ISSUE; otherwise it SHALL go to DONE.
REQ-010 In ISSUE with rnd_done=0, the block SHALL go to WAIT; WAIT SHALL hold with rnd_start=0 until rnd_done=1.
REQ-011 rnd_done in IDLE or DONE SHALL be ignored.
REQ-012 rnd_state_out SHALL equal the state register at all times.
REQ-013 rnd_idx, rnd_init and rnd_last SHALL be stable from ISSUE through capture.
REQ-014 In DONE, out_valid SHALL be 1 and out_state SHALL equal the state register, held stable until out_ready=1.
REQ-015 On out_valid&&out_ready the block SHALL return to IDLE; in_ready SHALL be 0 in that cycle (no same-cycle accept).
REQ-016 in_ready SHALL be 0 in ISSUE, WAIT and DONE; in_valid there SHALL have no effect.
REQ-017 Exactly NUM_ROUNDS+1 rnd_start pulses SHALL occur per request, with rnd_idx values 0..NUM_ROUNDS in order.
REQ-018 With rnd_done tied to rnd_start, accept at edge T SHALL give out_valid=1 at edge T+NUM_ROUNDS+2 (8 cycles at defaults).
REQ-019 The block SHALL perform no arithmetic on state words; they pass through unmodified between the ports and the state register.

Reset
REQ-020 reset==0 at a rising edge SHALL force IDLE, rnd_idx=0, state register=0, in_ready=1, out_valid=0, rnd_start=0 and busy=0 in the next cycle.
REQ-021 Reset mid-operation (ISSUE, WAIT or DONE) SHALL abort the request with no out_valid; a later rnd_done SHALL be ignored.
REQ-022 Outputs SHALL be undefined only before the first reset edge.

Verification
REQ-023 Combinational datapath (rnd_done=rnd_start, rnd_state_in = rnd_state_out+1 per word) with in_state all 0 -> out_state all 7, out_valid 8 cycles after accept, and rnd_idx seen as 0,1,...,6.
REQ-024 rnd_done delayed 3 cycles after each rnd_start -> 7 pulses each followed by WAIT, rnd_start never reasserted while waiting, same final out_state as REQ-023.
REQ-025 Hold out_ready=0 for 5 cycles in DONE while toggling in_valid and rnd_done -> out_state stable, in_ready=0, and exactly one output handshake when out_ready=1.
REQ-026 Assert reset=0 during the WAIT of round 3 -> next cycle IDLE with in_ready=1 and rnd_idx=0; a stale rnd_done gives no capture; a new request then completes normally.
REQ-027 Back-to-back requests with in_valid held high -> second accept no earlier than the cycle after the first output handshake, and both results correct.
REQ-028 Check rnd_init=1 only when rnd_idx=0 and rnd_last=1 only when rnd_idx=6, across all REQ-023 to REQ-027 runs.
